// File: rtl/coso_bit_packer.sv
`default_nettype none
// ============================================================================
// Module      : coso_bit_packer
// Description : Takes run-length results from the coherent-sampling counter,
//               uses COUNT[0] as a raw random bit, runs a repetition health
//               test on the counts, optionally debiases with a von Neumann
//               corrector and packs bits MSB-first into WIDTH-bit words on a
//               valid/ready output.
// Ports       : clk          system clock
//               rst          asynchronous active-high reset
//               i_count      run-length result
//               i_count_en   1-cycle strobe qualifying i_count
//               o_dout       packed word (first bit in MSB)
//               o_dout_valid o_dout holds an unconsumed word
//               i_dout_ready consumer accepts when valid & ready at posedge
//               o_drop       1-cycle pulse: completed word discarded
//               o_err        sticky repetition-test failure
//               i_err_clr    clears o_err and health/packing state
// Revision    : 1.0 - initial release
// ============================================================================
module coso_bit_packer #(
    parameter int WIDTH     = 32,
    parameter int VN_EN     = 1,
    parameter int REP_LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       i_count,
    input  logic             i_count_en,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_dout_valid,
    input  logic             i_dout_ready,
    output logic             o_drop,
    output logic             o_err,
    input  logic             i_err_clr
);

    localparam int              c_CW        = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST      = c_CW'(WIDTH - 1);
    localparam logic [7:0]      c_REP_LIMIT = 8'(REP_LIMIT);

    typedef enum logic [0:0] {
        VN_IDLE  = 1'b0,
        VN_HAVE1 = 1'b1
    } vn_state_t;

    logic [7:0]       r_prev_count;
    logic [7:0]       r_rep_cnt;
    logic             r_err;
    logic [WIDTH-2:0] r_sh;
    logic [c_CW-1:0]  r_bitcnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_drop;

    logic             w_raw;
    logic             w_take;
    logic [7:0]       w_rep_next;
    logic             w_err_set;
    logic             w_emit;
    logic             w_bit;
    logic [WIDTH-1:0] w_sh_full;
    logic             w_word_done;

    assign w_raw  = i_count[0];
    // A strobe coinciding with a clear is ignored; while in error no bits flow.
    assign w_take = i_count_en & ~i_err_clr & ~r_err;

    // ------------------------------------------------------------------
    // Repetition health test: runs on every strobe regardless of ERR/VN.
    // ------------------------------------------------------------------
    assign w_rep_next = (i_count == r_prev_count)
                      ? ((r_rep_cnt == 8'hFF) ? 8'hFF : r_rep_cnt + 8'd1)
                      : 8'd1;
    // Set is evaluated even under a clear so that a simultaneous set wins.
    assign w_err_set  = i_count_en & (w_rep_next == c_REP_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_count <= 8'd0;
            r_rep_cnt    <= 8'd0;
            r_err        <= 1'b0;
        end else begin
            if (i_err_clr) begin
                r_prev_count <= 8'd0;
                r_rep_cnt    <= 8'd0;
            end else if (i_count_en) begin
                r_prev_count <= i_count;
                r_rep_cnt    <= w_rep_next;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (i_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bit source: von Neumann corrector or raw pass-through.
    // ------------------------------------------------------------------
    generate
        if (VN_EN != 0) begin : g_vn
            vn_state_t r_vn_state;
            vn_state_t w_vn_next;
            logic      r_vn_b0;
            logic      w_vn_b0_next;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vn_state <= VN_IDLE;
                    r_vn_b0    <= 1'b0;
                end else begin
                    r_vn_state <= w_vn_next;
                    r_vn_b0    <= w_vn_b0_next;
                end
            end

            always_comb begin
                w_vn_next    = r_vn_state;
                w_vn_b0_next = r_vn_b0;
                w_emit       = 1'b0;
                w_bit        = r_vn_b0;
                if (i_err_clr) begin
                    w_vn_next = VN_IDLE;
                end else if (w_take) begin
                    case (r_vn_state)
                        VN_IDLE: begin
                            w_vn_next    = VN_HAVE1;
                            w_vn_b0_next = w_raw;
                        end
                        VN_HAVE1: begin
                            w_vn_next = VN_IDLE;
                            w_emit    = (r_vn_b0 != w_raw);
                        end
                        default: w_vn_next = VN_IDLE;
                    endcase
                end
            end
        end else begin : g_raw
            assign w_emit = w_take;
            assign w_bit  = w_raw;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Packing and output register. The shift register only holds WIDTH-1
    // bits; the completing bit is appended directly into the output word.
    // ------------------------------------------------------------------
    assign w_sh_full   = {r_sh, w_bit};
    assign w_word_done = w_emit & (r_bitcnt == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh     <= '0;
            r_bitcnt <= '0;
            r_dout   <= '0;
            r_valid  <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            if (i_err_clr) begin
                r_bitcnt <= '0;
            end else if (w_emit) begin
                r_sh     <= w_sh_full[WIDTH-2:0];
                r_bitcnt <= (r_bitcnt == c_LAST) ? '0 : r_bitcnt + c_CW'(1);
            end

            if (w_word_done && (!r_valid || i_dout_ready)) begin
                r_dout  <= w_sh_full;
                r_valid <= 1'b1;
            end else begin
                if (w_word_done) begin
                    r_drop <= 1'b1;
                end
                if (r_valid && i_dout_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign o_dout       = r_dout;
    assign o_dout_valid = r_valid;
    assign o_drop       = r_drop;
    assign o_err        = r_err;

endmodule
`default_nettype wire
